stopwatch_seq: RTL and testbench

STOPWATCH_SEQ -- requirements
Module: stopwatch_seq

---
 rtl/stopwatch_seq.sv | 170 +++++++++++++++++
 tb/tb_stopwatch_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: a tick ripples through six BCD digits over a shared external adder, 1-6 cycles per tick.
// One tick can queue during an update (a further one sets tick_ovr); lap capture exists only with STOPWATCH_LAP_EN.
module stopwatch_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_sum,
  input  logic        add_cout,
  output logic [23:0] time_bcd,
  output logic [23:0] lap_bcd,
  output logic        running,
  output logic        busy,
  output logic        wrap,
  output logic        tick_ovr
);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic        pending_q, pending_d;
  logic        tick_ovr_q, tick_ovr_d;
  logic        running_q, running_d;
  logic        wrap_q, wrap_d;
  logic [23:0] time_q, time_d;
  logic [3:0]  cur_digit, new_digit;
  logic        roll_digit, eff_carry, last_digit;

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_q, lap_d;
  logic        lap_pend_q, lap_pend_d;
`endif

  always_comb begin
    cur_digit  = time_q[{idx_q, 2'b00} +: 4];
    // Tens-of-seconds and tens-of-minutes digits count 0..5 only.
    roll_digit = ((idx_q == 3'd3) || (idx_q == 3'd5)) && (add_sum == 4'd6);
    new_digit  = roll_digit ? 4'd0 : add_sum;
    eff_carry  = roll_digit | add_cout;
    last_digit = (idx_q == 3'd5);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    pending_d  = pending_q;
    tick_ovr_d = tick_ovr_q;
    running_d  = running_q;
    wrap_d     = 1'b0;
    time_d     = time_q;
`ifdef STOPWATCH_LAP_EN
    lap_d      = lap_q;
    lap_pend_d = lap_pend_q;
`endif

    if (start_stop) begin
      running_d = ~running_q;
    end

    case (state_q)
      IDLE: begin
        if (running_q && (tick || pending_q)) begin
          state_d   = UPDATE;
          idx_d     = 3'd0;
          carry_d   = 1'b1;
          // A fresh tick arriving alongside a queued one takes the queue slot.
          pending_d = tick & pending_q;
        end
`ifdef STOPWATCH_LAP_EN
        if (lap || lap_pend_q) begin
          lap_d      = time_q;
          lap_pend_d = 1'b0;
        end
`endif
      end
      UPDATE: begin
        time_d[{idx_q, 2'b00} +: 4] = new_digit;
        if (!eff_carry || last_digit) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          carry_d = 1'b0;
          wrap_d  = eff_carry & last_digit;
        end else begin
          idx_d   = idx_q + 3'd1;
          carry_d = eff_carry;
        end
        if (tick && running_q) begin
          if (pending_q) begin
            tick_ovr_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
`ifdef STOPWATCH_LAP_EN
        if (lap) begin
          lap_pend_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d    = IDLE;
      idx_d      = 3'd0;
      carry_d    = 1'b0;
      pending_d  = 1'b0;
      tick_ovr_d = 1'b0;
      running_d  = running_q;
      wrap_d     = 1'b0;
      time_d     = 24'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      carry_q    <= 1'b0;
      pending_q  <= 1'b0;
      tick_ovr_q <= 1'b0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      time_q     <= 24'd0;
`ifdef STOPWATCH_LAP_EN
      lap_q      <= 24'd0;
      lap_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      pending_q  <= pending_d;
      tick_ovr_q <= tick_ovr_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
      time_q     <= time_d;
`ifdef STOPWATCH_LAP_EN
      lap_q      <= lap_d;
      lap_pend_q <= lap_pend_d;
`endif
    end
  end

  assign busy     = (state_q == UPDATE);
  assign add_a    = busy ? cur_digit : 4'd0;
  assign add_cin  = busy & carry_q;
  assign add_b    = 4'd0;
  assign time_bcd = time_q;
  assign running  = running_q;
  assign wrap     = wrap_q;
  assign tick_ovr = tick_ovr_q;

`ifdef STOPWATCH_LAP_EN
  assign lap_bcd = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = 24'd0;
`endif

endmodule

// File: tb/tb_stopwatch_seq.sv
// Scoreboard bench for stopwatch_seq with a behavioural BCD adder that can also preload digits.
module tb_stopwatch_seq;

  logic        clk;
  logic        rst_n;
  logic        tick, start_stop, clear, lap;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [23:0] time_bcd, lap_bcd;
  logic        running, busy, wrap, tick_ovr;

`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif

  typedef struct {
    logic [23:0] t;
    int          cyc;
    logic        w;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks, n_err;
  int          bcnt, wrap_cnt, w0;
  logic        bprev;
  logic        load_mode;
  logic [23:0] load_val;
  logic [2:0]  ld_idx;
  logic [4:0]  s;

  stopwatch_seq dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .time_bcd(time_bcd), .lap_bcd(lap_bcd), .running(running),
    .busy(busy), .wrap(wrap), .tick_ovr(tick_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preload mode forces the written digits to load_val, carrying through idx 4 and stopping at idx 5.
  always_comb begin
    s        = {1'b0, add_a} + {4'd0, add_cin};
    add_sum  = (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
    add_cout = (s >= 5'd10);
    if (load_mode) begin
      add_sum  = load_val[{ld_idx, 2'b00} +: 4];
      add_cout = (ld_idx != 3'd5);
    end
  end

  initial begin
    ld_idx = 3'd0;
    forever begin
      @(posedge clk);
      ld_idx <= busy ? ld_idx + 3'd1 : 3'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each completed update (busy falling) is matched against the oldest expectation.
  initial begin
    bcnt = 0; bprev = 1'b0; wrap_cnt = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
        check("add_cin_busy", 32'(add_cin), 32'd1);
      end else if (bprev) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("time", 32'(time_bcd), 32'(e.t));
          check("busy_cycles", 32'(bcnt), 32'(e.cyc));
          check("wrap", 32'(wrap), 32'(e.w));
        end
        bcnt = 0;
      end
      if (wrap) wrap_cnt++;
      bprev = busy;
    end
  end

  task automatic drive(input logic t, input logic ss, input logic cl, input logic lp);
    @(negedge clk);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(negedge clk);
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    check("idle", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic load(input logic [23:0] v);
    load_val  = v;
    load_mode = 1'b1;
    sb.push_back('{v, 6, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    load_mode = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    load_mode = 1'b0; load_val = 24'd0;
    rst_n = 1'b0; tick = 1'b1; start_stop = 1'b1; clear = 1'b1; lap = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_time", 32'(time_bcd), 32'd0);
    check("rst_lap", 32'(lap_bcd), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_ovr", 32'(tick_ovr), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    check("add_b", 32'(add_b), 32'd0);
    rst_n = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

    // First tick from zero: single digit touched.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_on", 32'(running), 32'd1);
    sb.push_back('{24'h000001, 1, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Ticks while stopped are ignored and leave nothing queued.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_off", 32'(running), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("stopped_time", 32'(time_bcd), 32'h000001);
    check("stopped_busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{24'h000002, 1, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();

    load(24'h000999);
    sb.push_back('{24'h001000, 4, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("idle_add_a", 32'(add_a), 32'd0);
    check("idle_add_cin", 32'(add_cin), 32'd0);

    // Three ticks in a row: one queued, one dropped.
    load(24'h000999);
    sb.push_back('{24'h001000, 4, 1'b0});
    sb.push_back('{24'h001001, 1, 1'b0});
    @(negedge clk); tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    wait_idle();
    check("ovr_set", 32'(tick_ovr), 32'd1);
    repeat (2) @(negedge clk);
    check("ovr_sticky", 32'(tick_ovr), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovr", 32'(tick_ovr), 32'd0);
    check("clr_time", 32'(time_bcd), 32'd0);
    check("clr_running", 32'(running), 32'd1);

    load(24'h595999);
    w0 = wrap_cnt;
    sb.push_back('{24'h000000, 6, 1'b1});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("wrap_count", 32'(wrap_cnt - w0), 32'd1);
    check("wrap_running", 32'(running), 32'd1);

    // Clear during the third update cycle aborts it.
    load(24'h000999);
    sb.push_back('{24'h000000, 3, 1'b0});
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    wait_idle();
    check("abort_time", 32'(time_bcd), 32'd0);

    // Lap during an update captures the post-update time.
    load(24'h000099);
    sb.push_back('{24'h000100, 3, 1'b0});
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; lap = 1'b1;
    @(negedge clk); lap = 1'b0;
    wait_idle();
    check("lap_deferred", 32'(lap_bcd), LAP_EN ? 32'h000100 : 32'd0);
    sb.push_back('{24'h000101, 1, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_idle", 32'(lap_bcd), LAP_EN ? 32'h000101 : 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_after_clr", 32'(lap_bcd), LAP_EN ? 32'h000101 : 32'd0);
    check("time_after_clr", 32'(time_bcd), 32'd0);

    // Reset mid-update wins over clear and leaves no partial write.
    load(24'h000999);
    sb.push_back('{24'h000000, 2, 1'b0});
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); rst_n = 1'b0; clear = 1'b1;
    @(negedge clk); rst_n = 1'b1; clear = 1'b0;
    @(negedge clk);
    check("mrst_time", 32'(time_bcd), 32'd0);
    check("mrst_running", 32'(running), 32'd0);
    check("mrst_lap", 32'(lap_bcd), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
